// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// the legal WIDTH range with its check function.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_fa.sv
// 1-bit full adder built from two half-adder stages; the two stage carries
// can never both be high, so an OR merges them.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g1;
  logic g2;

  assign p    = a ^ b;
  assign g1   = a & b;
  assign s    = p ^ cin;
  assign g2   = p & cin;
  assign cout = g1 | g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB first over
// WIDTH cycles. Optional signed-overflow output under SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("serial_add_ctrl: WIDTH must lie in 2..32");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  serial_fa u_fa (
    .a    (a_r[0]),
    .b    (b_r[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (cnt == CNT_LAST);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sum enters at the MSB so after WIDTH shifts bit 0 sits at sum[0].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_r   <= a_r >> 1;
          b_r   <= b_r >> 1;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          if (last_bit) cout <= fa_c;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // On the last bit the carry flop holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n)                           ovf <= 1'b0;
    else if (state == SHIFT && last_bit) ovf <= carry ^ fa_c;
  end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8); ovf is checked only
// when SERIAL_ADD_OVF_EN is defined for the build.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition, with signed overflow taken from the
  // operand and result sign bits.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    r = ref_add(x, y);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  task automatic check_result(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    r = ref_add(x, y);
    check({tag, "_sum"}, 64'(sum), 64'(r[WIDTH-1:0]));
    check({tag, "_cout"}, 64'(cout), 64'(r[WIDTH]));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(x, y)));
`endif
  endtask

  // One full operation from an idle DUT; operands are scrambled right after
  // capture to show they are not re-read.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int k;
    logic [WIDTH-1:0] held;
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) check({tag, "_busy_start"}, 64'(busy), 64'(1));
    end while (!done && k < 4 * WIDTH);
    check({tag, "_latency"}, 64'(k), 64'(WIDTH + 1));
    check({tag, "_busy_done"}, 64'(busy), 64'(1));
    check_result(tag, x, y);
    held = sum;
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    check({tag, "_sum_hold"}, 64'(sum), 64'(held));
  endtask

  initial begin : main
    logic [WIDTH-1:0] op_a [30];
    logic [WIDTH-1:0] op_b [30];
    int               done_at [$];
    logic [WIDTH-1:0] done_sum [$];
    logic             done_cout [$];
    int               n;
    int               k;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases
    run_op("p0f_01", 8'h0F, 8'h01);
    run_op("pff_01", 8'hFF, 8'h01);
    run_op("p7f_01", 8'h7F, 8'h01);
    run_op("pff_ff", 8'hFF, 8'hFF);
    run_op("p80_80", 8'h80, 8'h80);
    run_op("p00_00", 8'h00, 8'h00);

    // Random operands
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("rnd%0d", i), WIDTH'($urandom), WIDTH'($urandom));
    end

    // start held high for 30 cycles with operands changing every cycle
    for (int i = 0; i < 30; i++) begin
      op_a[i] = WIDTH'($urandom);
      op_b[i] = WIDTH'($urandom);
    end
    for (int i = 0; i < 42; i++) begin
      @(posedge clk); #1;
      if (i < 30) begin
        start = 1'b1; a = op_a[i]; b = op_b[i];
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        done_at.push_back(i);
        done_sum.push_back(sum);
        done_cout.push_back(cout);
      end
    end
    check("stream_done_count", 64'(done_at.size()), 64'(3));
    // Starts are accepted at the operands of steps 0, 10, 20.
    for (int j = 0; j < done_at.size() && j < 3; j++) begin
      logic [WIDTH:0] r;
      r = ref_add(op_a[10 * j], op_b[10 * j]);
      check($sformatf("stream%0d_sum", j), 64'(done_sum[j]), 64'(r[WIDTH-1:0]));
      check($sformatf("stream%0d_cout", j), 64'(done_cout[j]), 64'(r[WIDTH]));
      if (j > 0) check($sformatf("stream%0d_spacing", j), 64'(done_at[j] - done_at[j-1]), 64'(WIDTH + 2));
    end

    // Reset in the middle of 0xAA + 0x55
    @(posedge clk); #1;
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    n = 0;
    @(posedge clk);
    @(negedge clk);
    if (done) n++;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADD_OVF_EN
    check("midrst_ovf", 64'(ovf), 64'(0));
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2 * WIDTH) begin
      @(negedge clk);
      if (done) n++;
    end
    check("midrst_no_done", 64'(n), 64'(0));
    run_op("post_rst", 8'h01, 8'h02);

    // Back-to-back: second start held high until accepted
    @(posedge clk); #1;
    start = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    a = 8'hF0; b = 8'h20;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 4 * WIDTH);
    check("b2b_first_latency", 64'(k), 64'(WIDTH + 1));
    check_result("b2b_first", 8'h12, 8'h34);
    @(negedge clk);
    check("b2b_idle_hold", 64'(sum), 64'(8'h46));
    check("b2b_idle_busy", 64'(busy), 64'(0));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 4 * WIDTH);
    check("b2b_second_latency", 64'(k), 64'(WIDTH + 1));
    check_result("b2b_second", 8'hF0, 8'h20);
    @(posedge clk); #1;
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
